// File: rtl/console_arbiter.sv
// Round-robin arbiter that shares one Wishbone console slave between N masters.
// The grant is held for the owner's whole CYC, and a per-transfer watchdog returns ERR when the slave never ACKs.
module console_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_MASTERS-1:0]    m_cyc,
  input  logic [N_MASTERS-1:0]    m_stb,
  input  logic [N_MASTERS-1:0]    m_we,
  input  logic [N_MASTERS*AW-1:0] m_adr,
  input  logic [N_MASTERS*DW-1:0] m_dat_w,
  output logic [DW-1:0]           m_dat_r,
  output logic [N_MASTERS-1:0]    m_ack,
  output logic [N_MASTERS-1:0]    m_err,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [AW-1:0]           s_adr,
  output logic [DW-1:0]           s_dat_w,
  input  logic [DW-1:0]           s_dat_r,
  input  logic                    s_ack,
  output logic [N_MASTERS-1:0]    grant
);

  localparam int GW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_ERR} state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        g_q, g_d;
  logic [GW-1:0]        rr_q, rr_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [WDW-1:0]       wdog_q, wdog_d;
  logic                 err_q, err_d;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic [GW-1:0] rr_next;
  logic          sel_cyc, sel_stb, sel_we;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_dat;
  logic          timeout;
  logic          own;

  // The first requester at or above rr_q, wrapping around, wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!pick_found && m_cyc[(int'(rr_q) + i) % N_MASTERS]) begin
        pick_found = 1'b1;
        pick_idx   = GW'((int'(rr_q) + i) % N_MASTERS);
      end
    end
  end

  always_comb begin
    rr_next = (int'(g_q) == N_MASTERS - 1) ? '0 : GW'(int'(g_q) + 1);
    sel_cyc = m_cyc[g_q];
    sel_stb = m_stb[g_q];
    sel_we  = m_we[g_q];
    sel_adr = m_adr[int'(g_q)*AW +: AW];
    sel_dat = m_dat_w[int'(g_q)*DW +: DW];
    timeout = (TIMEOUT_CYCLES != 0) && sel_stb && !s_ack && (wdog_q == WD_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    wdog_d  = wdog_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_OWN;
          g_d     = pick_idx;
          grant_d = N_MASTERS'(1) << pick_idx;
          wdog_d  = '0;
        end
      end
      ST_OWN: begin
        if (!sel_cyc) begin
          state_d = ST_IDLE;
          rr_d    = rr_next;
          grant_d = '0;
          wdog_d  = '0;
        end else if (timeout) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          wdog_d  = '0;
        end else if (sel_stb && !s_ack) begin
          wdog_d = wdog_q + 1'b1;
        end else begin
          wdog_d = '0;
        end
      end
      ST_ERR: begin
        if (!sel_cyc) begin
          state_d = ST_IDLE;
          rr_d    = rr_next;
          grant_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outside OWN the console sees an idle bus and any late ACK is dropped.
  always_comb begin
    own     = (state_q == ST_OWN);
    s_cyc   = own && sel_cyc;
    s_stb   = own && sel_stb;
    s_we    = own && sel_we;
    s_adr   = own ? sel_adr : '0;
    s_dat_w = own ? sel_dat : '0;
    m_ack   = (own && s_ack) ? grant_q : '0;
    m_err   = err_q ? grant_q : '0;
    m_dat_r = s_dat_r;
    grant   = grant_q;
  end

endmodule
